// File: rtl/port_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready output port among N_REQ requesters.
// A grant lasts until the owner's last beat or HOLD_MAX beats, then priority rotates.

module port_rr_lane #(
  parameter int IW  = 2,
  parameter int IDX = 0
) (
  input  logic          busy,
  input  logic [IW-1:0] grant_id,
  input  logic          out_ready,
  output logic          ready
);
  assign ready = busy && (grant_id == IW'(IDX)) && out_ready;
endmodule

module port_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4,
  localparam int IW      = $clog2(N_REQ),
  localparam int CW      = $clog2(HOLD_MAX+1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [IW-1:0]           grant_id,
  output logic                    busy
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          found;
  logic [IW-1:0] pick;
  logic          xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign busy     = (state_q == GRANT);
  assign grant_id = grant_q;

  // Each lane raises its ready only while it owns the port.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    port_rr_lane #(.IW(IW), .IDX(i)) u_lane (
      .busy      (busy),
      .grant_id  (grant_q),
      .out_ready (out_ready),
      .ready     (req_ready[i])
    );
  end

  assign out_valid = busy && req_valid[grant_q];
  assign out_data  = busy ? req_data[grant_q*DATA_W +: DATA_W] : '0;
  assign out_last  = out_valid && (req_last[grant_q] || (beat_cnt_q == CW'(HOLD_MAX-1)));
  assign xfer      = out_valid && out_ready;

  // First pending requester at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin : arb
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = rr_ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          grant_d    = pick;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (out_last) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == IW'(N_REQ-1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_port_rr_arbiter.sv
// Bench for port_rr_arbiter: directed scenarios plus randomized packet streams
// checked against a packet-level round-robin model.

module tb_port_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int HM = 4;

  logic            clk = 0;
  logic            rst_n = 0;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;
  logic [1:0]      grant_id;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  logic [8:0]  srcq [N][$];
  logic [10:0] expq [$];

  port_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic drive();
    logic [8:0] b;
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        b = srcq[i][0];
        req_valid[i] = 1'b1;
        req_last[i]  = b[8];
        req_data[i*DW +: DW] = b[7:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    acc = req_valid & req_ready;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    drive();
  endtask

  task automatic load(input int id, input int len, input logic [7:0] base);
    for (int b = 0; b < len; b++) srcq[id].push_back({(b == len-1), 8'(base + b)});
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) srcq[i].delete();
  endtask

  task automatic do_reset();
    rst_n = 0;
    out_ready = 0;
    clear_src();
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    mptr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    out_ready = 0;
    clear_src();
    drive();
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", grant_id); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
    tick();
  endtask

  task automatic test_single_stream();
    do_reset();
    out_ready = 1;
    load(2, 3, 8'hA1);
    drive();
    for (int c = 0; c <= 4; c++) begin
      logic eb;
      eb = (c >= 1 && c <= 3);
      @(negedge clk);
      checks++; if (busy !== eb) begin errors++; $display("FAIL single_busy c%0d got %b exp %b", c, busy, eb); end
      checks++; if (out_valid !== eb) begin errors++; $display("FAIL single_valid c%0d got %b exp %b", c, out_valid, eb); end
      if (eb) begin
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_gid c%0d got %0d exp 2", c, grant_id); end
        checks++; if (out_data !== 8'(8'hA0 + c)) begin errors++; $display("FAIL single_data c%0d got %h exp %h", c, out_data, 8'(8'hA0 + c)); end
        checks++; if (out_last !== (c == 3)) begin errors++; $display("FAIL single_last c%0d got %b exp %b", c, out_last, (c == 3)); end
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready c%0d got %b exp 0100", c, req_ready); end
      end
      tick();
    end
    // rr_ptr should now sit at 3, so requester 3 wins when everyone asks
    for (int i = 0; i < N; i++) load(i, 1, 8'(8'h80 + i));
    drive();
    @(negedge clk); tick();
    @(negedge clk);
    checks++; if (busy !== 1'b1 || grant_id !== 2'd3) begin errors++; $display("FAIL single_rrptr got busy %b gid %0d exp busy 1 gid 3", busy, grant_id); end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) load(i, 1, 8'(i*16 + k));
    drive();
    for (int c = 0; c < 10; c++) begin
      logic eb;
      logic [1:0] eg;
      eb = (c % 2 == 1);
      eg = 2'(((c - 1) / 2) % N);
      @(negedge clk);
      checks++; if (busy !== eb) begin errors++; $display("FAIL rr_busy c%0d got %b exp %b", c, busy, eb); end
      if (eb) begin
        checks++; if (grant_id !== eg) begin errors++; $display("FAIL rr_gid c%0d got %0d exp %0d", c, grant_id, eg); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL rr_last c%0d got %b exp 1", c, out_last); end
      end
      tick();
    end
  endtask

  task automatic test_hold_max_cut();
    do_reset();
    out_ready = 1;
    load(0, 6, 8'h10);
    drive();
    for (int c = 0; c <= 8; c++) begin
      logic eb, el;
      int   bi;
      eb = (c >= 1 && c <= 4) || c == 6 || c == 7;
      el = (c == 4 || c == 7);
      bi = (c <= 4) ? c - 1 : c - 2;
      @(negedge clk);
      checks++; if (busy !== eb) begin errors++; $display("FAIL hold_busy c%0d got %b exp %b", c, busy, eb); end
      if (eb) begin
        checks++; if (out_data !== 8'(8'h10 + bi)) begin errors++; $display("FAIL hold_data c%0d got %h exp %h", c, out_data, 8'(8'h10 + bi)); end
        checks++; if (out_last !== el) begin errors++; $display("FAIL hold_last c%0d got %b exp %b", c, out_last, el); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL hold_gid c%0d got %0d exp 0", c, grant_id); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    load(1, 5, 8'h30);
    drive();
    for (int c = 0; c <= 9; c++) begin
      logic eb, el;
      logic [7:0] ed;
      out_ready = !(c >= 2 && c <= 4);
      eb = (c >= 1 && c <= 7) || c == 9;
      el = (c == 7 || c == 9);
      ed = (c == 1) ? 8'h30 : (c <= 5) ? 8'h31 : (c == 9) ? 8'h34 : 8'(8'h30 + c - 4);
      @(negedge clk);
      checks++; if (busy !== eb) begin errors++; $display("FAIL bp_busy c%0d got %b exp %b", c, busy, eb); end
      if (eb) begin
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL bp_gid c%0d got %0d exp 1", c, grant_id); end
        checks++; if (out_data !== ed) begin errors++; $display("FAIL bp_data c%0d got %h exp %h", c, out_data, ed); end
        checks++; if (out_last !== el) begin errors++; $display("FAIL bp_last c%0d got %b exp %b", c, out_last, el); end
        checks++; if (req_ready !== (out_ready ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL bp_ready c%0d got %b", c, req_ready); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    out_ready = 1;
    load(1, 6, 8'h50);
    drive();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); tick();
    end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || out_data !== 8'h52) begin errors++; $display("FAIL mid_pre got busy %b data %h exp busy 1 data 52", busy, out_data); end
    rst_n = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL mid_ready got %b exp 0000", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    clear_src();
    load(0, 1, 8'h60);
    load(1, 1, 8'h70);
    drive();
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle got %b exp 0", busy); end
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0 || out_data !== 8'h60) begin
      errors++; $display("FAIL mid_first got busy %b gid %0d data %h exp 1 0 60", busy, grant_id, out_data);
    end
    tick();
  endtask

  // Packet-level reference: grant order and beat split from the queued streams.
  task automatic build_model();
    logic [8:0] mq [N][$];
    logic [8:0] b;
    int id, n;
    logic lo, fnd;
    for (int i = 0; i < N; i++) mq[i] = srcq[i];
    forever begin
      fnd = 0; id = 0;
      for (int k = 0; k < N; k++)
        if (!fnd && mq[(mptr + k) % N].size() > 0) begin fnd = 1; id = (mptr + k) % N; end
      if (!fnd) break;
      n = 0; lo = 0;
      while (!lo && mq[id].size() > 0) begin
        b = mq[id].pop_front();
        n++;
        lo = b[8] || (n == HM);
        expq.push_back({2'(id), lo, b[7:0]});
      end
      mptr = (id + 1) % N;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      int cyc;
      for (int i = 0; i < N; i++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 7);
          for (int b = 0; b < len; b++) srcq[i].push_back({(b == len-1), 8'($urandom)});
        end
      end
      build_model();
      drive();
      cyc = 0;
      while (expq.size() > 0 && cyc < 3000) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        checks++; if ($countones(req_ready) > 1) begin errors++; $display("FAIL rnd_onehot got %b", req_ready); end
        checks++; if (out_valid && !busy) begin errors++; $display("FAIL rnd_idle_valid got valid %b busy %b", out_valid, busy); end
        if (out_valid && out_ready) begin
          checks++;
          if ({grant_id, out_last, out_data} !== expq[0]) begin
            errors++;
            $display("FAIL rnd_beat got gid %0d last %b data %h exp gid %0d last %b data %h",
                     grant_id, out_last, out_data, expq[0][10:9], expq[0][8], expq[0][7:0]);
          end
          void'(expq.pop_front());
        end
        tick();
        cyc++;
      end
      checks++; if (expq.size() != 0) begin errors++; $display("FAIL rnd_timeout got %0d beats left exp 0", expq.size()); end
      expq.delete();
      clear_src();
      drive();
      @(negedge clk); tick();
    end
  endtask

  initial begin
    out_ready = 0;
    clear_src();
    drive();
    test_reset();
    test_single_stream();
    test_round_robin();
    test_hold_max_cut();
    test_backpressure();
    test_reset_mid_grant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
